// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around one shared 1-bit
// full adder. Operands are consumed LSB first, one bit per clock, and the
// WIDTH-bit result plus carry-out is presented with a one-cycle done pulse.
//
// Optional build macro: SERIAL_ADD_OVF_EN
//   When defined, adds output ovf (two's-complement signed overflow of the
//   addition), registered with sum/cout and held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// RUN   | one operand bit pair added per clock, LSB first
// DONE  | result registered; done pulses for this single cycle

module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, done_q;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  fulladd u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // Next-state, shift-register and result-capture logic
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          res_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        if (last_bit) begin
          // Counter stays at its last value so it never exceeds WIDTH-1
          sum_d   = {fa_sum, res_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered busy/done decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry_q ^ fa_cout;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) until done is seen high; n = edges waited
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) n_checks = n_checks; // expected ovf unused in this build
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int n;
    int seen_done;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Asynchronous reset mid-cycle
    #12;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    do_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("carry_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("noovf_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    // start re-asserted during RUN is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h10;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'h00;
    wait_done(n);
    check("ignore_latency", 32'(n), 32'd5);
    check("ignore_sum", 32'(sum), 32'h02);
    check("ignore_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;

    // start held high: completions every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    wait_done(n);
    check("held_first_done", 32'(done), 32'd1);
    check("held_first_sum", 32'(sum), 32'h33);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 30);
    start = 1'b0;
    check("held_interval", 32'(n), 32'd10);
    check("held_second_sum", 32'(sum), 32'h33);
    repeat (2) @(posedge clk);
    #1;
    check("held_release_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'h00);
    check("midrst_cout", 32'(cout), 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_sum_after", 32'(sum), 32'h00);
    do_op("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
